accelerator_top: RTL and testbench

- CSR-to-MVU command bridge between the multi-hart pito RISC-V core and the MVU array; one MVU job slot per hart.
- Harts write job parameters into per-hart CSRs. A COMMAND write launches the job on that hart's MVU.
- The block tracks busy/done per hart and raises a per-hart interrupt on completion.

---
 rtl/accelerator_top.sv | 152 +++++++++++++++
 tb/tb_accelerator_top.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/accelerator_top.sv
// CSR-to-MVU command bridge: per-hart job CSRs, start/done tracking and irqs.
// Optional per-hart busy-cycle counter at 0xF28 enabled by ACCEL_PERF_CNT_EN.
module accelerator_top #(
    parameter int NUM_HARTS = 8,
    parameter int XLEN      = 32,
    parameter int HART_W    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    csr_we,
    input  logic                    csr_re,
    input  logic [HART_W-1:0]       csr_hart,
    input  logic [11:0]             csr_addr,
    input  logic [XLEN-1:0]         csr_wdata,
    output logic [XLEN-1:0]         csr_rdata,
    output logic                    csr_rvalid,
    output logic [NUM_HARTS-1:0]    mvu_start,
    output logic [NUM_HARTS*32-1:0] mvu_wbase,
    output logic [NUM_HARTS*32-1:0] mvu_ibase,
    output logic [NUM_HARTS*32-1:0] mvu_obase,
    output logic [NUM_HARTS*16-1:0] mvu_len,
    output logic [NUM_HARTS*12-1:0] mvu_prec,
    input  logic [NUM_HARTS-1:0]    mvu_done,
    output logic [NUM_HARTS-1:0]    irq
);

    localparam logic [11:0] A_WBASE  = 12'hF20;
    localparam logic [11:0] A_IBASE  = 12'hF21;
    localparam logic [11:0] A_OBASE  = 12'hF22;
    localparam logic [11:0] A_LEN    = 12'hF23;
    localparam logic [11:0] A_PREC   = 12'hF24;
    localparam logic [11:0] A_STATUS = 12'hF25;
    localparam logic [11:0] A_IRQCLR = 12'hF26;
    localparam logic [11:0] A_CMD    = 12'hF27;
    localparam logic [11:0] A_PERF   = 12'hF28;

    typedef enum logic {IDLE, BUSY} state_t;

    logic [XLEN-1:0] rd_val [NUM_HARTS];

    for (genvar i = 0; i < NUM_HARTS; i++) begin : g_hart
        state_t      state;
        logic [31:0] wbase, ibase, obase;
        logic [15:0] len;
        logic [11:0] prec;
        logic [31:0] wbase_q, ibase_q, obase_q;
        logic [15:0] len_q;
        logic [11:0] prec_q;
        logic        start_q, irq_pend, err;
        logic        wr, busy, cmd, done_hit, accept;
        logic [31:0] perf;

        assign wr       = csr_we && (csr_hart == HART_W'(i));
        assign busy     = (state == BUSY);
        assign cmd      = wr && (csr_addr == A_CMD);
        assign done_hit = mvu_done[i] && busy;
        // A same-cycle done frees the slot before the command is judged
        assign accept   = cmd && (!busy || done_hit);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= IDLE;
                wbase    <= '0;
                ibase    <= '0;
                obase    <= '0;
                len      <= '0;
                prec     <= '0;
                wbase_q  <= '0;
                ibase_q  <= '0;
                obase_q  <= '0;
                len_q    <= '0;
                prec_q   <= '0;
                start_q  <= 1'b0;
                irq_pend <= 1'b0;
                err      <= 1'b0;
            end else begin
                start_q <= accept;
                if (wr && csr_addr == A_WBASE) wbase <= csr_wdata[31:0];
                if (wr && csr_addr == A_IBASE) ibase <= csr_wdata[31:0];
                if (wr && csr_addr == A_OBASE) obase <= csr_wdata[31:0];
                if (wr && csr_addr == A_LEN)   len   <= csr_wdata[15:0];
                if (wr && csr_addr == A_PREC)  prec  <= csr_wdata[11:0];
                if (accept) begin
                    wbase_q <= wbase;
                    ibase_q <= ibase;
                    obase_q <= obase;
                    len_q   <= len;
                    prec_q  <= prec;
                end
                unique case (state)
                    IDLE:    if (accept) state <= BUSY;
                    BUSY:    if (mvu_done[i] && !accept) state <= IDLE;
                    default: state <= IDLE;
                endcase
                if (done_hit)
                    irq_pend <= 1'b1;
                else if (wr && csr_addr == A_IRQCLR && csr_wdata[0])
                    irq_pend <= 1'b0;
                if (cmd && !accept)
                    err <= 1'b1;
                else if (wr && csr_addr == A_IRQCLR && csr_wdata[2])
                    err <= 1'b0;
            end
        end

`ifdef ACCEL_PERF_CNT_EN
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                perf <= '0;
            else if (accept)
                perf <= '0;
            else if (busy && perf != 32'hFFFF_FFFF)
                perf <= perf + 32'd1;
        end
`else
        assign perf = '0;
`endif

        always_comb begin
            rd_val[i] = '0;
            unique case (csr_addr)
                A_WBASE:  rd_val[i] = XLEN'(wbase);
                A_IBASE:  rd_val[i] = XLEN'(ibase);
                A_OBASE:  rd_val[i] = XLEN'(obase);
                A_LEN:    rd_val[i] = XLEN'(len);
                A_PREC:   rd_val[i] = XLEN'(prec);
                A_STATUS: rd_val[i] = XLEN'({err, irq_pend, busy});
                A_PERF:   rd_val[i] = XLEN'(perf);
                default:  rd_val[i] = '0;
            endcase
        end

        assign mvu_start[i]          = start_q;
        assign irq[i]                = irq_pend;
        assign mvu_wbase[32*i +: 32] = wbase_q;
        assign mvu_ibase[32*i +: 32] = ibase_q;
        assign mvu_obase[32*i +: 32] = obase_q;
        assign mvu_len[16*i +: 16]   = len_q;
        assign mvu_prec[12*i +: 12]  = prec_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_rdata  <= '0;
            csr_rvalid <= 1'b0;
        end else begin
            csr_rvalid <= csr_re;
            if (csr_re) csr_rdata <= rd_val[csr_hart];
        end
    end

endmodule

// File: tb/tb_accelerator_top.sv
// Directed self-checking bench for accelerator_top.
module tb_accelerator_top;
    localparam int NH = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            csr_we = 1'b0;
    logic            csr_re = 1'b0;
    logic [2:0]      csr_hart = '0;
    logic [11:0]     csr_addr = '0;
    logic [31:0]     csr_wdata = '0;
    logic [31:0]     csr_rdata;
    logic            csr_rvalid;
    logic [NH-1:0]   mvu_start;
    logic [NH*32-1:0] mvu_wbase, mvu_ibase, mvu_obase;
    logic [NH*16-1:0] mvu_len;
    logic [NH*12-1:0] mvu_prec;
    logic [NH-1:0]   mvu_done = '0;
    logic [NH-1:0]   irq;

    int n_chk = 0;
    int n_ok  = 0;
    logic [31:0] rv;

    accelerator_top dut (
        .clk(clk), .rst_n(rst_n),
        .csr_we(csr_we), .csr_re(csr_re),
        .csr_hart(csr_hart), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .csr_rvalid(csr_rvalid), .mvu_start(mvu_start),
        .mvu_wbase(mvu_wbase), .mvu_ibase(mvu_ibase),
        .mvu_obase(mvu_obase), .mvu_len(mvu_len),
        .mvu_prec(mvu_prec), .mvu_done(mvu_done), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_ok++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wr(input int h, input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_we = 1'b1; csr_hart = 3'(h); csr_addr = a; csr_wdata = d;
        @(negedge clk);
        csr_we = 1'b0;
    endtask

    task automatic rd(input int h, input logic [11:0] a, output logic [31:0] d);
        @(negedge clk);
        csr_re = 1'b1; csr_hart = 3'(h); csr_addr = a;
        @(negedge clk);
        csr_re = 1'b0;
        if (!csr_rvalid) $display("FAIL rvalid: got 0 expected 1");
        d = csr_rdata;
    endtask

    task automatic done(input logic [NH-1:0] m);
        @(negedge clk);
        mvu_done = m;
        @(negedge clk);
        mvu_done = '0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_start", mvu_start, 0);
        check("rst_irq", irq, 0);
        check("rst_wbase", mvu_wbase[63:0], 0);
        check("rst_rvalid", csr_rvalid, 0);
        rd(0, 12'hF25, rv); check("rst_status0", rv, 0);
        rd(7, 12'hF25, rv); check("rst_status7", rv, 0);

        wr(2, 12'hF20, 32'h100);
        wr(2, 12'hF21, 32'h200);
        wr(2, 12'hF22, 32'h300);
        wr(2, 12'hF23, 32'h40);
        wr(2, 12'hF24, 32'h222);
        check("pre_start_wbase", mvu_wbase[95:64], 0);
        wr(2, 12'hF27, 32'h0);
        check("start_h2", mvu_start, 8'h04);
        check("wbase_h2", mvu_wbase[95:64], 32'h100);
        check("ibase_h2", mvu_ibase[95:64], 32'h200);
        check("obase_h2", mvu_obase[95:64], 32'h300);
        check("len_h2", mvu_len[47:32], 16'h40);
        check("prec_h2", mvu_prec[35:24], 12'h222);
        @(negedge clk);
        check("start_pulse_end", mvu_start, 0);
        rd(2, 12'hF25, rv); check("status_busy", rv, 1);
        rd(2, 12'hF20, rv); check("wbase_rb", rv, 32'h100);

        wr(4, 12'hF23, 32'hFFFF_1234);
        rd(4, 12'hF23, rv); check("len_mask", rv, 32'h1234);
        rd(4, 12'hF30, rv); check("unmapped_rd", rv, 0);
        rd(4, 12'hF27, rv); check("cmd_rd0", rv, 0);
        wr(4, 12'hF25, 32'h7);
        rd(4, 12'hF25, rv); check("status_ro", rv, 0);

        @(negedge clk);
        csr_we = 1'b1; csr_re = 1'b1; csr_hart = 3'd4;
        csr_addr = 12'hF20; csr_wdata = 32'h77;
        @(negedge clk);
        csr_we = 1'b0; csr_re = 1'b0;
        check("rw_same_cycle", csr_rdata, 0);
        rd(4, 12'hF20, rv); check("rw_after", rv, 32'h77);

        done(8'h04);
        check("irq_h2", irq, 8'h04);
        rd(2, 12'hF25, rv); check("status_done", rv, 2);
        wr(2, 12'hF26, 32'h1);
        check("irq_clr", irq, 0);
        rd(2, 12'hF25, rv); check("status_clr", rv, 0);

        done(8'h40);
        check("done_idle", irq, 0);

        wr(5, 12'hF27, 32'h0);
        check("start_h5", mvu_start, 8'h20);
        wr(5, 12'hF20, 32'h555);
        check("hold_busy_cfg", mvu_wbase[191:160], 0);
        wr(5, 12'hF27, 32'h0);
        check("no_start_busy", mvu_start, 0);
        rd(5, 12'hF25, rv); check("status_err", rv, 5);
        wr(5, 12'hF26, 32'h4);
        rd(5, 12'hF25, rv); check("err_clr", rv, 1);
        done(8'h20);
        wr(5, 12'hF26, 32'h1);
        check("h5_clean", irq, 0);

        wr(0, 12'hF27, 32'h0);
        @(negedge clk);
        mvu_done = 8'h01;
        csr_we = 1'b1; csr_hart = 3'd0; csr_addr = 12'hF27;
        @(negedge clk);
        mvu_done = '0; csr_we = 1'b0;
        check("sim_start", mvu_start, 8'h01);
        check("sim_irq", irq, 8'h01);
        rd(0, 12'hF25, rv); check("sim_status", rv, 3);

        wr(1, 12'hF27, 32'h0);
        wr(3, 12'hF27, 32'h0);
        done(8'h0A);
        check("multi_done", irq, 8'h0B);

        wr(7, 12'hF27, 32'h0);
        repeat (9) @(negedge clk);
        mvu_done = 8'h80;
        @(negedge clk);
        mvu_done = '0;
        rd(7, 12'hF28, rv);
`ifdef ACCEL_PERF_CNT_EN
        check("perfcnt", rv, 10);
`else
        check("perfcnt", rv, 0);
`endif
        check("irq_h7", irq[7], 1);

        #2 rst_n = 1'b0;
        #1 check("midrst_irq", irq, 0);
        check("midrst_start", mvu_start, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done(8'h01);
        check("done_after_rst", irq, 0);
        rd(0, 12'hF25, rv); check("status_after_rst", rv, 0);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
